// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, multiplier FSM states and the legal-opcode check for alu_pipe.
// Contents:
//   OP_W        opcode width (5)
//   alu_op_e    opcode encodings
//   mul_st_e    iterative multiplier states
//   is_legal_op 1 when the opcode is decoded (MULU only with ALU_PIPE_MUL_EN)
package alu_pipe_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ROLV  = 5'b00000,
        OP_RORV  = 5'b00001,
        OP_NOT   = 5'b00010,
        OP_NORI  = 5'b00111,
        OP_BLEU  = 5'b01000,
        OP_ADD   = 5'b10000,
        OP_ADD_A = 5'b10001,
        OP_NOR   = 5'b10011,
        OP_ADD_B = 5'b10101,
        OP_MULU  = 5'b11000
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } mul_st_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
`ifdef ALU_PIPE_MUL_EN
        return op inside {OP_ROLV, OP_RORV, OP_NOT, OP_NORI, OP_BLEU,
                          OP_ADD, OP_ADD_A, OP_NOR, OP_ADD_B, OP_MULU};
`else
        return op inside {OP_ROLV, OP_RORV, OP_NOT, OP_NORI, OP_BLEU,
                          OP_ADD, OP_ADD_A, OP_NOR, OP_ADD_B};
`endif
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response handshake bundle between register-read and writeback.
// Signals:
//   in_valid/in_ready    request handshake; in_op, in_a, in_b request payload
//   out_valid/out_ready  response handshake; out_result, out_zero, out_cond, out_illegal payload
// Modports: master (producer/consumer side), slave (the ALU).
interface alu_pipe_if
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_cond;
    logic             out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_cond, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_cond, out_illegal
    );

endinterface

// File: rtl/alu_pipe_rot.sv
// alu_pipe_rot: combinational logarithmic barrel rotator.
// Ports:
//   dir_i   0 = rotate left, 1 = rotate right
//   amt_i   rotate amount, full log2(WIDTH) range
//   data_i  value to rotate
//   data_o  rotated value
module alu_pipe_rot #(
    parameter int WIDTH = 32
) (
    input  logic                     dir_i,
    input  logic [$clog2(WIDTH)-1:0] amt_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o
);
    localparam int ROT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] st [ROT_W+1];

    assign st[0] = data_i;

    // Stage g rotates by 2**g when amount bit g is set.
    for (genvar g = 0; g < ROT_W; g++) begin : g_stage
        localparam int S = 1 << g;
        assign st[g+1] = !amt_i[g] ? st[g]
                       : dir_i     ? {st[g][S-1:0], st[g][WIDTH-1:S]}
                       :             {st[g][WIDTH-S-1:0], st[g][WIDTH-1:WIDTH-S]};
    end

    assign data_o = st[ROT_W];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU (ADD/NOR/NORI/NOT/BLEU/ROLV/RORV) with valid/ready backpressure.
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset, drops all in-flight ops
//   bus    alu_pipe_if.slave: request in_*, response out_*
// Optional: define ALU_PIPE_MUL_EN to add MULU (11000), an iterative shift-add multiplier
// that stalls S1 for WIDTH+2 cycles; otherwise 11000 is an illegal opcode.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);
    localparam int ROT_W = $clog2(WIDTH);

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, cond_q, ill_q;

    logic             in_ready, in_fire, s2_free, s1_adv, s1_clr, s2_load, mul_load;
    logic [WIDTH-1:0] rot_res, alu_res, ld_res;
    logic             alu_cond, alu_ill;

    assign s2_free    = ~s2_valid_q | bus.out_ready;
    // in_ready must read low throughout reset, hence the rst_n gate.
    assign in_ready   = rst_n & (~s1_valid_q | s1_clr);
    assign in_fire    = bus.in_valid & in_ready;
    assign s1_clr     = s1_adv | mul_load;
    assign s2_load    = s1_clr;
    assign s1_valid_d = in_fire ? 1'b1 : s1_clr ? 1'b0 : s1_valid_q;
    assign s2_valid_d = s2_load ? 1'b1 : bus.out_ready ? 1'b0 : s2_valid_q;

    alu_pipe_rot #(.WIDTH(WIDTH)) u_rot (
        .dir_i  (s1_op_q == OP_RORV),
        .amt_i  (s1_a_q[ROT_W-1:0]),
        .data_i (s1_b_q),
        .data_o (rot_res)
    );

    always_comb begin
        alu_res  = '0;
        alu_cond = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_ADD_A, OP_ADD_B: alu_res = s1_a_q + s1_b_q;
            OP_NOR, OP_NORI:            alu_res = ~(s1_a_q | s1_b_q);
            OP_NOT:                     alu_res = ~s1_b_q;
            OP_BLEU: begin
                alu_cond = s1_a_q <= s1_b_q;
                alu_res  = WIDTH'(alu_cond);
            end
            OP_ROLV, OP_RORV:           alu_res = rot_res;
            default:                    alu_res = '0;
        endcase
    end

    assign alu_ill = ~is_legal_op(s1_op_q);

`ifdef ALU_PIPE_MUL_EN
    mul_st_e          st_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [ROT_W:0]   cnt_q;

    assign s1_adv   = s1_valid_q & s2_free & (st_q == ST_IDLE) & (s1_op_q != OP_MULU);
    assign mul_load = (st_q == ST_DONE) & s2_free;
    assign ld_res   = mul_load ? acc_q : alu_res;

    // The start cycle already folds in multiplier bit 0, so ST_MUL covers bits 1..WIDTH-1
    // and the result reaches S2 exactly WIDTH+2 cycles after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (st_q)
                ST_IDLE: if (s1_valid_q && s1_op_q == OP_MULU) begin
                    acc_q    <= s1_b_q[0] ? s1_a_q : '0;
                    mcand_q  <= s1_a_q << 1;
                    mplier_q <= s1_b_q >> 1;
                    cnt_q    <= (ROT_W+1)'(1);
                    st_q     <= ST_MUL;
                end
                ST_MUL: begin
                    acc_q    <= mplier_q[0] ? acc_q + mcand_q : acc_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    st_q     <= cnt_q == (ROT_W+1)'(WIDTH-1) ? ST_DONE : ST_MUL;
                end
                ST_DONE: st_q <= s2_free ? ST_IDLE : ST_DONE;
                default: st_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign s1_adv   = s1_valid_q & s2_free;
    assign mul_load = 1'b0;
    assign ld_res   = alu_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_op_q <= bus.in_op;
                s1_a_q  <= bus.in_a;
                s1_b_q  <= bus.in_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            cond_q     <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                res_q  <= ld_res;
                zero_q <= ld_res == '0;
                cond_q <= alu_cond;
                ill_q  <= alu_ill;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_result  = res_q;
    assign bus.out_zero    = zero_q;
    assign bus.out_cond    = cond_q;
    assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe with directed tests and a randomized reference model.
module tb_alu_pipe;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         i;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    res_t exp_q[$];
    res_t got_q[$];
    int n_checks = 0;
    int n_fail = 0;

    function automatic res_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t m;
        int n;
        m = '0;
        n = int'(a % W);
        case (op)
            5'b10000, 5'b10001, 5'b10101: m.r = a + b;
            5'b10011, 5'b00111:           m.r = ~(a | b);
            5'b00010:                     m.r = ~b;
            5'b01000: begin m.c = (a <= b); m.r = {31'd0, m.c}; end
            5'b00000: m.r = (n == 0) ? b : (b << n) | (b >> (W - n));
            5'b00001: m.r = (n == 0) ? b : (b >> n) | (b << (W - n));
`ifdef ALU_PIPE_MUL_EN
            5'b11000: m.r = W'({32'd0, a} * {32'd0, b});
`endif
            default:  m.i = 1'b1;
        endcase
        m.z = (m.r == 0);
        return m;
    endfunction

    task automatic tick(output bit fired);
        #2;
        fired = bus.in_valid && bus.in_ready;
        if (fired) exp_q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
        if (bus.out_valid && bus.out_ready)
            got_q.push_back(res_t'{bus.out_result, bus.out_zero, bus.out_cond, bus.out_illegal});
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit f = 0;
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        while (!f && k < 100) begin tick(f); k++; end
        if (!f) begin n_checks++; n_fail++; $display("FAIL issue_timeout op=%b not accepted, required accept within 100 cycles", op); end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit f;
        int k = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while (got_q.size() < exp_q.size() && k < 500) begin tick(f); k++; end
        if (got_q.size() < exp_q.size()) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout got %0d results, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        bit f;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        n_checks++; if (bus.out_result !== '0) begin n_fail++; $display("FAIL rst_result got %h want 0", bus.out_result); end
        n_checks++; if ({bus.out_zero, bus.out_cond, bus.out_illegal} !== 3'b000) begin
            n_fail++; $display("FAIL rst_flags got z/c/i=%b%b%b want 000", bus.out_zero, bus.out_cond, bus.out_illegal);
        end
        rst_n = 1'b1;
        tick(f);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_add_latency();
        bit f;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = 5'b10000; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'h1;
        tick(f);
        n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL add_accept got %b want 1", f); end
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_lat_n1 got out_valid=%b want 0", bus.out_valid); end
        tick(f);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_lat_n2 got out_valid=%b want 1", bus.out_valid); end
        n_checks++; if (bus.out_result !== 32'h0) begin n_fail++; $display("FAIL add_wrap got %h want 00000000", bus.out_result); end
        n_checks++; if ({bus.out_zero, bus.out_cond, bus.out_illegal} !== 3'b100) begin
            n_fail++; $display("FAIL add_flags got z/c/i=%b%b%b want 100", bus.out_zero, bus.out_cond, bus.out_illegal);
        end
        tick(f);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained got out_valid=%b want 0", bus.out_valid); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_rotate_bleu();
        logic [4:0]   ops [10] = '{5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b01000,
                                   5'b01000, 5'b00010, 5'b00111, 5'b10011, 5'b10101};
        logic [W-1:0] as [10]  = '{32'h24, 32'h24, 32'h20, 32'h1F, 32'd5,
                                   32'd6, 32'h1234, 32'hF0F0_F0F0, 32'h0, 32'h7};
        logic [W-1:0] bs [10]  = '{32'h8000_0001, 32'h8000_0001, 32'hDEAD_BEEF, 32'h1, 32'd5,
                                   32'd5, 32'hFFFF_FFFF, 32'hF, 32'h0, 32'h8};
        res_t want [10] = '{
            res_t'{32'h0000_0018, 1'b0, 1'b0, 1'b0},
            res_t'{32'h1800_0000, 1'b0, 1'b0, 1'b0},
            res_t'{32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0},
            res_t'{32'h0000_0002, 1'b0, 1'b0, 1'b0},
            res_t'{32'h0000_0001, 1'b0, 1'b1, 1'b0},
            res_t'{32'h0000_0000, 1'b1, 1'b0, 1'b0},
            res_t'{32'h0000_0000, 1'b1, 1'b0, 1'b0},
            res_t'{32'h0F0F_0F00, 1'b0, 1'b0, 1'b0},
            res_t'{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
            res_t'{32'h0000_000F, 1'b0, 1'b0, 1'b0}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) issue(ops[i], as[i], bs[i]);
        drain();
        n_checks++; if (got_q.size() != 10) begin n_fail++; $display("FAIL dir_count got %0d want 10", got_q.size()); end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== want[i]) begin
                n_fail++;
                $display("FAIL dir[%0d] op=%b got r=%h z=%b c=%b i=%b want r=%h z=%b c=%b i=%b", i, ops[i],
                         got_q[i].r, got_q[i].z, got_q[i].c, got_q[i].i, want[i].r, want[i].z, want[i].c, want[i].i);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_illegal();
`ifdef ALU_PIPE_MUL_EN
        logic [4:0] ops [2] = '{5'b11111, 5'b00011};
`else
        logic [4:0] ops [3] = '{5'b11111, 5'b00011, 5'b11000};
`endif
        res_t want = res_t'{32'h0, 1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        foreach (ops[i]) issue(ops[i], 32'h5, 32'h9);
        drain();
        n_checks++; if (got_q.size() != $size(ops)) begin n_fail++; $display("FAIL ill_count got %0d want %0d", got_q.size(), $size(ops)); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== want) begin
                n_fail++;
                $display("FAIL ill[%0d] got r=%h z=%b c=%b i=%b want r=0 z=1 c=0 i=1", i,
                         got_q[i].r, got_q[i].z, got_q[i].c, got_q[i].i);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [4:0] tab [9] = '{5'b00000, 5'b00001, 5'b00010, 5'b00111, 5'b01000,
                                5'b10000, 5'b10001, 5'b10011, 5'b10101};
        logic [4:0]   ops [8];
        logic [W-1:0] as [8];
        logic [W-1:0] bs [8];
        res_t snap;
        bit f;
        int idx = 0;
        int c = 0;
        snap = '0;
        for (int i = 0; i < 8; i++) begin
            ops[i] = tab[$urandom_range(0, 8)];
            as[i] = $urandom;
            bs[i] = $urandom;
        end
        while ((idx < 8 || got_q.size() < 8) && c < 100) begin
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid = (idx < 8);
            if (idx < 8) begin bus.in_op = ops[idx]; bus.in_a = as[idx]; bus.in_b = bs[idx]; end
            #1;
            if (c <= 2) begin
                n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble c=%0d got in_ready=%b want 1", c, bus.in_ready); end
            end
            if (c == 3) begin
                snap = res_t'{bus.out_result, bus.out_zero, bus.out_cond, bus.out_illegal};
                n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_valid got %b want 1", bus.out_valid); end
            end
            if (c >= 3 && c <= 6) begin
                n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready c=%0d got %b want 0", c, bus.in_ready); end
            end
            if (c >= 4 && c <= 6) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || res_t'{bus.out_result, bus.out_zero, bus.out_cond, bus.out_illegal} !== snap) begin
                    n_fail++;
                    $display("FAIL b2b_frozen c=%0d got v=%b r=%h want v=1 r=%h", c, bus.out_valid, bus.out_result, snap.r);
                end
            end
            tick(f);
            if (f) idx++;
            c++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (got_q.size() != 8 || exp_q.size() != 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d] got r=%h z=%b c=%b i=%b want r=%h z=%b c=%b i=%b", i,
                         got_q[i].r, got_q[i].z, got_q[i].c, got_q[i].i, exp_q[i].r, exp_q[i].z, exp_q[i].c, exp_q[i].i);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        logic [4:0] tab [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00111, 5'b01000,
                                 5'b10000, 5'b10001, 5'b10011, 5'b10101, 5'b11000, 5'b00000};
        bit f;
        int acc = 0;
        int c = 0;
        while (acc < 150 && c < 20000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : tab[$urandom_range(0, 10)];
            bus.in_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.in_b = ($urandom_range(0, 3) == 0) ? bus.in_a + 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
            tick(f);
            if (f) acc++;
            c++;
        end
        drain();
        n_checks++; if (got_q.size() != exp_q.size() || acc != 150) begin
            n_fail++; $display("FAIL rand_count got %0d results for %0d accepts, want 150/150", got_q.size(), acc);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand[%0d] got r=%h z=%b c=%b i=%b want r=%h z=%b c=%b i=%b", i,
                         got_q[i].r, got_q[i].z, got_q[i].c, got_q[i].i, exp_q[i].r, exp_q[i].z, exp_q[i].c, exp_q[i].i);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_async_reset();
        bit f;
        bus.out_ready = 1'b0;
        issue(5'b10000, 32'd1, 32'd2);
        issue(5'b10000, 32'd3, 32'd4);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_inflight got out_valid=%b want 1", bus.out_valid); end
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_immediate got out_valid=%b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got %b want 0", bus.in_ready); end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete(); got_q.delete();
        bus.out_ready = 1'b1;
        repeat (4) tick(f);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL arst_dropped got %0d stale results want 0", got_q.size()); end
        exp_q.delete(); got_q.delete();
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul();
        bit f;
        int k = 0;
        bus.out_ready = 1'b1;
        issue(5'b11000, 32'h0001_0001, 32'h0001_0001);
        while (!bus.out_valid && k < 100) begin
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready k=%0d got %b want 0", k, bus.in_ready); end
            tick(f);
            k++;
        end
        n_checks++; if (k + 1 != W + 2) begin n_fail++; $display("FAIL mul_latency got %0d want %0d", k + 1, W + 2); end
        n_checks++; if (bus.out_result !== 32'h0002_0001) begin n_fail++; $display("FAIL mul_result got %h want 00020001", bus.out_result); end
        drain();
        exp_q.delete(); got_q.delete();
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        test_reset();
        test_add_latency();
        test_rotate_bleu();
        test_illegal();
        test_back_to_back();
`ifdef ALU_PIPE_MUL_EN
        test_mul();
`endif
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor of the datapath ALU. Registers operands and opcode, computes ADD/NOR/NORI/NOT/BLEU/ROLV/RORV at configurable width, and returns the result through a valid/ready handshake with full backpressure. Rotates cover the full log2(WIDTH) amount in both directions. Sits between the register-read stage and writeback/branch logic.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8.
ROT_W, $clog2(WIDTH), localparam: rotate-amount bits taken from in_a.

Ports:
clk  input  1  single clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request presented.
in_ready  output  1  request accepted when in_valid & in_ready.
in_op  input  5  opcode (package constants).
in_a  input  WIDTH  operand A; also rotate amount.
in_b  input  WIDTH  operand B; rotate source; zero-extended immediate for NORI.
out_valid  output  1  result held.
out_ready  input  1  consumer accepts when out_valid & out_ready.
out_result  output  WIDTH  result.
out_zero  output  1  out_result == 0.
out_cond  output  1  BLEU outcome; 0 for other ops.
out_illegal  output  1  opcode not decoded; out_result = 0.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, FSM=IDLE, out_valid=0, out_result=0, out_zero=0, out_cond=0, out_illegal=0, in_ready=0 while in reset. Deassertion mid-transaction drops all in-flight ops.
- Stage S1: captures op/a/b on accept. Stage S2: holds computed result, drives outputs directly from flops.
- s2_free = ~s2_valid | out_ready. s1_adv = s1_valid & s2_free & (FSM==IDLE) & op not MULU. in_ready = ~s1_valid | s1_adv (combinational, no in_valid dependency).
- Latency: accept at cycle N -> out_valid at N+2. Throughput one op/cycle with out_ready held high.
- out_valid low -> S2 may load. out_valid high and out_ready low -> S2, S1 and all outputs hold stable; in_ready=0 once S1 full.
- Opcodes: ADD 10000, 10001, 10101: a+b mod 2^WIDTH, carry discarded. NOR 10011 and NORI 00111: ~(a|b). NOT 00010: ~b. BLEU 01000: cond = (a <= b) unsigned, result = zero-extended cond. ROLV 00000: b rotated left by a[ROT_W-1:0]. RORV 00001: b rotated right by the same amount. Upper bits of a are ignored for rotates. Amount 0 -> b unchanged.
- Any other opcode: result 0, out_illegal=1, out_zero=1, out_cond=0. Still handshakes normally with 2-cycle latency.
- out_zero is computed for every op, including illegal ops.
- Simultaneous accept-in and drain-out in the same cycle is required. No bubble at steady state.

Optional Feature:
Macro ALU_PIPE_MUL_EN.
- Defined: opcode MULU 11000 = low WIDTH bits of unsigned a*b.
  - Iterative shift-add multiplier, FSM IDLE -> MUL (WIDTH cycles, 5-bit-plus counter) -> DONE.
  - DONE loads S2 when s2_free, then returns to IDLE.
  - S1 stalls throughout; latency = WIDTH+2 cycles.
  - Reset in MUL -> IDLE, partial product discarded.
- Undefined: 11000 is illegal; FSM logic absent.

Decomposition:
- Package alu_pipe_pkg: opcode localparams/enum alu_op_e (5-bit), fsm state enum, function is_legal_op.
- Sub-module alu_pipe_rot (WIDTH, dir input), combinational log-shifter, instantiated once with a direction select.
- Multiplier inline under the macro.

Test Plan:
- Reset then ADD a=0xFFFFFFFF b=0x00000001, out_ready=1 -> out_valid on cycle 2, result 0x0, out_zero=1.
- ROLV a=0x24 (amount 4) b=0x80000001 -> 0x00000018. RORV same inputs -> 0x18000000. Rotate amount 0 -> b.
- BLEU a=5 b=5 -> cond=1, result=1. BLEU a=6 b=5 -> cond=0, result=0, out_zero=1.
- Back-to-back 8 ops, out_ready low for cycles 3-6 -> outputs frozen, in_ready drops, no loss or duplication, order preserved.
- Illegal op 11111 -> out_illegal=1, result 0. Async rst_n pulse with 2 ops in flight -> out_valid=0 immediately.
- With ALU_PIPE_MUL_EN: MULU a=0x10001 b=0x10001 -> 0x00020001 after 34 cycles. in_ready=0 during MUL.
